mem_port_arbiter: RTL and testbench

Arbitrates one single-port synchronous memory between the CPU's instruction-fetch port, the CPU's data load/store port and a program-loader port. After reset it runs in a load phase: only the loader is served and the CPU is stalled. Once the loader signals completion it switches to a run phase and round-robins between fetch and data. It sits between the CPU core and the shared instruction/data memory.

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: loader, fetch and data request ports plus the
// shared single-port memory. The arbiter takes the slave view.
interface mem_port_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_done;
   logic          ld_gnt;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [DW-1:0] dm_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          cpu_stall;

   modport slave (
      input  ld_req, ld_addr, ld_wdata, ld_done,
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output ld_gnt, if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output cpu_stall
   );

   modport master (
      output ld_req, ld_addr, ld_wdata, ld_done,
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  ld_gnt, if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  cpu_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: a loader-only LOAD phase after reset, then a RUN
// phase that round-robins instruction fetch and data accesses, one per cycle.
module mem_port_arbiter (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic {LOAD, RUN} phase_t;

   phase_t phase_q, phase_d;
   logic   last_dm_q, last_dm_d;
   logic   own_vld_q, own_vld_d;
   logic   own_dm_q, own_dm_d;
   logic   ld_gnt, if_gnt, dm_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= LOAD;
         last_dm_q <= 1'b1;
         own_vld_q <= 1'b0;
         own_dm_q  <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         last_dm_q <= last_dm_d;
         own_vld_q <= own_vld_d;
         own_dm_q  <= own_dm_d;
      end
   end

   // Grants are purely combinational; rst masks them so nothing reaches memory.
   always_comb begin
      phase_d   = phase_q;
      last_dm_d = last_dm_q;
      own_vld_d = 1'b0;
      own_dm_d  = own_dm_q;
      ld_gnt    = 1'b0;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;

      if (!rst) begin
         unique case (phase_q)
            LOAD: begin
               ld_gnt = bus.ld_req;
               if (bus.ld_done) phase_d = RUN;
            end
            RUN: begin
               if (bus.if_req && bus.dm_req) begin
                  if_gnt = last_dm_q;
                  dm_gnt = !last_dm_q;
               end else begin
                  if_gnt = bus.if_req;
                  dm_gnt = bus.dm_req;
               end
            end
            default: phase_d = LOAD;
         endcase
      end

      if (if_gnt) begin
         last_dm_d = 1'b0;
         own_vld_d = 1'b1;
         own_dm_d  = 1'b0;
      end else if (dm_gnt) begin
         last_dm_d = 1'b1;
         own_vld_d = !bus.dm_we;
         own_dm_d  = 1'b1;
      end
   end

   always_comb begin
      bus.ld_gnt    = ld_gnt;
      bus.if_gnt    = if_gnt;
      bus.dm_gnt    = dm_gnt;
      bus.cpu_stall = rst || (phase_q == LOAD);
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      if (ld_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = 1'b1;
         bus.mem_addr  = bus.ld_addr;
         bus.mem_wdata = bus.ld_wdata;
      end else if (if_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_addr  = bus.if_addr;
      end else if (dm_gnt) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.dm_we;
         bus.mem_addr  = bus.dm_addr;
         bus.mem_wdata = bus.dm_wdata;
      end

      // Read data is steered to whichever port owned last cycle's read.
      bus.if_rvalid = own_vld_q && !own_dm_q;
      bus.dm_rvalid = own_vld_q && own_dm_q;
      bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
      bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants checked in the request cycle,
// read data checked by a queue-based monitor against a behavioural memory.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t        if_q[$];
   exp_t        dm_q[$];
   logic [31:0] mem [0:1023];

   mem_port_arbiter_if #(.AW(10), .DW(32)) ifc ();

   mem_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (ifc.mem_en) begin
         if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
         else            ifc.mem_rdata     <= mem[ifc.mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: an rvalid must appear exactly in the cycle the queue head names.
   always @(negedge clk) begin
      logic ev_if, ev_dm;
      ev_if = (if_q.size() > 0) && (if_q[0].cyc == cyc);
      ev_dm = (dm_q.size() > 0) && (dm_q[0].cyc == cyc);
      chk("if_rvalid", {31'b0, ifc.if_rvalid}, {31'b0, ev_if});
      chk("dm_rvalid", {31'b0, ifc.dm_rvalid}, {31'b0, ev_dm});
      if (ev_if) begin
         chk("if_rdata", ifc.if_rdata, if_q[0].data);
         void'(if_q.pop_front());
      end else begin
         chk("if_rdata_idle", ifc.if_rdata, 32'h0);
      end
      if (ev_dm) begin
         chk("dm_rdata", ifc.dm_rdata, dm_q[0].data);
         void'(dm_q.pop_front());
      end else begin
         chk("dm_rdata_idle", ifc.dm_rdata, 32'h0);
      end
   end

   task automatic push_if(input logic [31:0] d);
      if_q.push_back('{cyc: cyc + 1, data: d});
   endtask

   task automatic push_dm(input logic [31:0] d);
      dm_q.push_back('{cyc: cyc + 1, data: d});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l_req, input logic [9:0] l_addr, input logic [31:0] l_wd,
                        input logic l_done, input logic i_req, input logic [9:0] i_addr,
                        input logic d_req, input logic d_we, input logic [9:0] d_addr,
                        input logic [31:0] d_wd);
      ifc.ld_req   = l_req;
      ifc.ld_addr  = l_addr;
      ifc.ld_wdata = l_wd;
      ifc.ld_done  = l_done;
      ifc.if_req   = i_req;
      ifc.if_addr  = i_addr;
      ifc.dm_req   = d_req;
      ifc.dm_we    = d_we;
      ifc.dm_addr  = d_addr;
      ifc.dm_wdata = d_wd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
   endtask

   task automatic expect_out(input string tag, input logic l, input logic i, input logic d,
                             input logic en, input logic we, input logic [9:0] addr,
                             input logic [31:0] wd, input logic stall);
      chk({tag, ".ld_gnt"},    {31'b0, ifc.ld_gnt},    {31'b0, l});
      chk({tag, ".if_gnt"},    {31'b0, ifc.if_gnt},    {31'b0, i});
      chk({tag, ".dm_gnt"},    {31'b0, ifc.dm_gnt},    {31'b0, d});
      chk({tag, ".mem_en"},    {31'b0, ifc.mem_en},    {31'b0, en});
      chk({tag, ".mem_we"},    {31'b0, ifc.mem_we},    {31'b0, we});
      chk({tag, ".mem_addr"},  {22'b0, ifc.mem_addr},  {22'b0, addr});
      chk({tag, ".mem_wdata"}, ifc.mem_wdata,          wd);
      chk({tag, ".cpu_stall"}, {31'b0, ifc.cpu_stall}, {31'b0, stall});
   endtask

   initial begin
      ifc.mem_rdata = 32'h0;
      idle();

      // Reset: loader request must not be granted while rst is high.
      next_cycle();
      drive(1'b1, 10'd3, 32'h33, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("reset", 0, 0, 0, 0, 0, 10'd0, 32'h0, 1);
      next_cycle();
      rst = 1'b0;
      idle();
      expect_out("post_reset", 0, 0, 0, 0, 0, 10'd0, 32'h0, 1);

      // LOAD phase: CPU ports get nothing.
      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 10'd0, 32'h0);
      expect_out("load_cpu_blocked", 0, 0, 0, 0, 0, 10'd0, 32'h0, 1);

      next_cycle();
      drive(1'b1, 10'd0, 32'h11, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("ld_w0", 1, 0, 0, 1, 1, 10'd0, 32'h11, 1);
      next_cycle();
      drive(1'b1, 10'd1, 32'h22, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("ld_w1", 1, 0, 0, 1, 1, 10'd1, 32'h22, 1);
      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("ld_done", 0, 0, 0, 0, 0, 10'd0, 32'h0, 1);
      next_cycle();
      idle();
      expect_out("run_entry", 0, 0, 0, 0, 0, 10'd0, 32'h0, 0);

      // RUN: loader and ld_done ignored.
      next_cycle();
      drive(1'b1, 10'd9, 32'h99, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("run_ld_ignored", 0, 0, 0, 0, 0, 10'd0, 32'h0, 0);

      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("fetch_alone", 0, 1, 0, 1, 0, 10'd1, 32'h0, 0);
      push_if(32'h22);

      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 32'h0);
      expect_out("data_alone", 0, 0, 1, 1, 0, 10'd0, 32'h0, 0);
      push_dm(32'h11);

      // Sustained conflict: alternate starting with fetch (data was last granted).
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd1, 1'b1, 1'b0, 10'd0, 32'h0);
         if (k % 2 == 0) begin
            expect_out($sformatf("conflict%0d_I", k), 0, 1, 0, 1, 0, 10'd1, 32'h0, 0);
            push_if(32'h22);
         end else begin
            expect_out($sformatf("conflict%0d_D", k), 0, 0, 1, 1, 0, 10'd0, 32'h0, 0);
            push_dm(32'h11);
         end
      end

      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
      expect_out("data_write", 0, 0, 1, 1, 1, 10'd5, 32'hDEADBEEF, 0);
      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("fetch_after_write", 0, 1, 0, 1, 0, 10'd5, 32'h0, 0);
      push_if(32'hDEADBEEF);
      next_cycle();
      idle();
      expect_out("run_idle", 0, 0, 0, 0, 0, 10'd0, 32'h0, 0);

      // Mid-operation reset while fetch is requesting.
      next_cycle();
      rst = 1'b1;
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("mid_reset", 0, 0, 0, 0, 0, 10'd0, 32'h0, 1);
      next_cycle();
      rst = 1'b0;
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("reload_fetch_blocked0", 0, 0, 0, 0, 0, 10'd0, 32'h0, 1);
      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("reload_fetch_blocked1", 0, 0, 0, 0, 0, 10'd0, 32'h0, 1);

      // Loader write in the same cycle as ld_done is still served.
      next_cycle();
      drive(1'b1, 10'd7, 32'h77, 1'b1, 1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0);
      expect_out("ld_with_done", 1, 0, 0, 1, 1, 10'd7, 32'h77, 1);

      // Pointer reset to "data": fetch wins the first conflict.
      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 10'd1, 32'h0);
      expect_out("first_conflict_I", 0, 1, 0, 1, 0, 10'd7, 32'h0, 0);
      push_if(32'h77);
      next_cycle();
      drive(1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd1, 32'h0);
      expect_out("data_after_reload", 0, 0, 1, 1, 0, 10'd1, 32'h0, 0);
      push_dm(32'h22);

      next_cycle();
      idle();
      next_cycle();
      next_cycle();
      chk("if_q_drained", if_q.size(), 32'd0);
      chk("dm_q_drained", dm_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
